// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a hold limit and a bus-turnaround cycle.
// A requester owns the grant while it holds req. After MAX_HOLD consecutive cycles
// the grant is revoked, but only if someone else is waiting. Every grant is followed
// by at least one idle cycle. All outputs come straight from flops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; next set req bit at or after ptr wins on the edge
// S_GRANT | gnt_idx owns the resource; hcnt counts consecutive cycles
module rr_arbiter8 #(
   parameter int MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       forced
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t        state_q;
   logic [2:0]    ptr_q;
   logic [HW-1:0] hcnt_q;

   logic [2:0]    sel_idx_d;
   logic [2:0]    cand;
   logic [7:0]    others;

   // Rotating priority search: scan offsets high to low so the nearest set bit at or after ptr wins
   always_comb begin
      sel_idx_d = ptr_q;
      cand      = ptr_q;
      for (int i = 7; i >= 0; i--) begin
         cand = ptr_q + 3'(i);
         if (req[cand]) sel_idx_d = cand;
      end
   end

   // Requests other than the current owner, used to decide whether the hold limit forces a release
   always_comb begin
      others = req & ~(8'b1 << gnt_idx);
   end

   // Arbitration FSM with registered grant outputs and the one-cycle forced pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= 3'd0;
         hcnt_q    <= '0;
         gnt       <= 8'h00;
         gnt_idx   <= 3'd0;
         gnt_valid <= 1'b0;
         forced    <= 1'b0;
      end else begin
         forced <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (|req) begin
                  state_q   <= S_GRANT;
                  gnt_idx   <= sel_idx_d;
                  gnt       <= 8'b1 << sel_idx_d;
                  gnt_valid <= 1'b1;
                  hcnt_q    <= HOLD_ONE;
               end
            end
            S_GRANT: begin
               if (!req[gnt_idx] || ((hcnt_q == HOLD_MAX) && (|others))) begin
                  // Release (voluntary or forced); pointer moves past the old owner for fairness
                  state_q   <= S_IDLE;
                  ptr_q     <= gnt_idx + 3'd1;
                  hcnt_q    <= '0;
                  gnt       <= 8'h00;
                  gnt_idx   <= 3'd0;
                  gnt_valid <= 1'b0;
                  forced    <= req[gnt_idx];
               end else if (hcnt_q != HOLD_MAX) begin
                  hcnt_q <= hcnt_q + HOLD_ONE;
               end else begin
                  // Sole requester at the limit keeps the bus; start a new hold window
                  hcnt_q <= HOLD_ONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD = 4). Each step drives req, queues the
// outputs expected after the next rising edge, then pops and checks them 1 ns later.
module tb_rr_arbiter8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       forced;

   int checks = 0;
   int errors = 0;

   logic [8:0] sb_q[$];   // {forced, gnt}
   string      tag_q[$];

   rr_arbiter8 #(.MAX_HOLD(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .gnt_valid(gnt_valid),
      .forced   (forced)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] idx_of(input logic [7:0] oh);
      idx_of = 3'd0;
      for (int i = 0; i < 8; i++) if (oh[i]) idx_of = 3'(i);
   endfunction

   function automatic logic [7:0] onehot(input int k);
      logic [7:0] v;
      v = 8'h00;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic expect_out(input logic [7:0] eg, input logic ef, input string tag);
      sb_q.push_back({ef, eg});
      tag_q.push_back(tag);
   endtask

   task automatic check_pop();
      logic [8:0] e;
      logic [7:0] eg;
      logic       ef;
      string      t;
      e  = sb_q.pop_front();
      t  = tag_q.pop_front();
      eg = e[7:0];
      ef = e[8];
      checks++;
      assert (gnt === eg) else begin
         errors++;
         $error("FAIL %s gnt got %h exp %h", t, gnt, eg);
      end
      checks++;
      assert (gnt_idx === idx_of(eg)) else begin
         errors++;
         $error("FAIL %s gnt_idx got %0d exp %0d", t, gnt_idx, idx_of(eg));
      end
      checks++;
      assert (gnt_valid === (eg != 8'h00)) else begin
         errors++;
         $error("FAIL %s gnt_valid got %b exp %b", t, gnt_valid, (eg != 8'h00));
      end
      checks++;
      assert (forced === ef) else begin
         errors++;
         $error("FAIL %s forced got %b exp %b", t, forced, ef);
      end
   endtask

   // Drive req, queue what should appear after the next edge, then sample and compare
   task automatic cyc(input logic [7:0] r, input logic [7:0] eg, input logic ef, input string tag);
      req = r;
      expect_out(eg, ef, tag);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      #12;
      expect_out(8'h00, 1'b0, "reset");
      check_pop();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic grant, release, turnaround and pointer advance
      cyc(8'h00, 8'h00, 1'b0, "idle_noreq");
      cyc(8'h24, 8'h04, 1'b0, "s27_grant2");
      cyc(8'h24, 8'h04, 1'b0, "s27_hold2");
      cyc(8'h20, 8'h00, 1'b0, "s27_turn");
      cyc(8'h20, 8'h20, 1'b0, "s27_grant5");
      cyc(8'h00, 8'h00, 1'b0, "s27_rel5");

      // Reset again so the full rotation starts from pointer 0
      #3;
      rst_n = 1'b0;
      #1;
      expect_out(8'h00, 1'b0, "reset2");
      check_pop();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // All requesting: each owner keeps the bus 3 cycles, then drops
      for (int k = 0; k < 8; k++) begin
         cyc(8'hFF, onehot(k), 1'b0, $sformatf("s28_grant%0d", k));
         cyc(8'hFF, onehot(k), 1'b0, $sformatf("s28_hold%0d_a", k));
         cyc(8'hFF, onehot(k), 1'b0, $sformatf("s28_hold%0d_b", k));
         cyc(8'hFF & ~onehot(k), 8'h00, 1'b0, $sformatf("s28_turn%0d", k));
      end
      cyc(8'hFF, 8'h01, 1'b0, "s28_wrap_grant0");
      cyc(8'h00, 8'h00, 1'b0, "s28_rel0");

      // Owner 7 releases, pointer wraps to 0, then 0 beats 7
      cyc(8'h80, 8'h80, 1'b0, "s31_grant7");
      cyc(8'h00, 8'h00, 1'b0, "s31_rel7");

      // Hold limit with a competitor: 4 grant cycles, forced idle, then 7
      cyc(8'h81, 8'h01, 1'b0, "s31_grant0");
      cyc(8'h81, 8'h01, 1'b0, "s29_hold2");
      cyc(8'h81, 8'h01, 1'b0, "s29_hold3");
      cyc(8'h81, 8'h01, 1'b0, "s29_hold4");
      cyc(8'h81, 8'h00, 1'b1, "s29_forced");
      cyc(8'h81, 8'h80, 1'b0, "s29_grant7");
      cyc(8'h00, 8'h00, 1'b0, "s29_rel7");

      // Sole requester keeps the bus past the limit, never forced
      for (int c = 0; c < 20; c++) begin
         cyc(8'h01, 8'h01, 1'b0, $sformatf("s30_solo%0d", c));
      end
      cyc(8'h00, 8'h00, 1'b0, "s30_rel0");

      // Non-owner request changes do not disturb the grant
      cyc(8'h01, 8'h01, 1'b0, "s20_grant0");
      cyc(8'hF1, 8'h01, 1'b0, "s20_noise_a");
      cyc(8'h31, 8'h01, 1'b0, "s20_noise_b");
      cyc(8'h30, 8'h00, 1'b0, "s20_turn");
      cyc(8'h30, 8'h10, 1'b0, "s20_grant4");
      cyc(8'h00, 8'h00, 1'b0, "s20_rel4");

      // Asynchronous reset in the middle of a grant to 3
      cyc(8'h08, 8'h08, 1'b0, "s32_grant3");
      cyc(8'h08, 8'h08, 1'b0, "s32_hold3");
      #2;
      rst_n = 1'b0;
      #1;
      expect_out(8'h00, 1'b0, "s32_async_drop");
      check_pop();
      req = 8'h0C;
      @(posedge clk);
      #1;
      expect_out(8'h00, 1'b0, "s32_in_reset");
      check_pop();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_out(8'h04, 1'b0, "s32_grant2");
      check_pop();
      cyc(8'h00, 8'h00, 1'b0, "s32_rel2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, meaning the maximum consecutive grant cycles before a forced release; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req, input, 8, with bit i the request from requester i, level-sensitive, held while ownership is wanted.
REQ-005 SHALL have port gnt, output reg, 8, a one-hot grant, all zero when no owner.
REQ-006 SHALL have port gnt_idx, output reg, 3, the binary index of the owner, 0 when no owner.
REQ-007 SHALL have port gnt_valid, output reg, 1, high exactly when gnt is non-zero.
REQ-008 SHALL have port forced, output reg, 1, a one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-009 SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-010 SHALL keep an internal 3-bit priority pointer ptr and a hold counter hcnt of width ceil(log2(MAX_HOLD+1)).
REQ-011 In IDLE with req != 0 at edge N, SHALL select the first set req bit searching ptr, ptr+1, ... ptr+7 (mod 8).
REQ-012 After edge N in REQ-011, SHALL have state GRANT, gnt_idx = the selected index, gnt = decode(gnt_idx), gnt_valid = 1, and hcnt = 1; this is a one-edge request-to-grant latency.
REQ-013 In IDLE with req == 0, SHALL hold all outputs at zero and leave ptr unchanged.
REQ-014 In GRANT, gnt SHALL always equal the 3-to-8 one-hot decode of gnt_idx, with bit gnt_idx set and all others clear.
REQ-015 In GRANT with req[gnt_idx] = 0 at an edge, SHALL go to IDLE with outputs zeroed after that edge and ptr = gnt_idx+1 mod 8 (wraps 7 -> 0).
REQ-016 In GRANT with req[gnt_idx] = 1 and hcnt < MAX_HOLD, SHALL increment hcnt and keep the grant.
REQ-017 In GRANT with req[gnt_idx] = 1, hcnt == MAX_HOLD, and any other req bit set, SHALL go to IDLE, set ptr = gnt_idx+1 mod 8, and pulse forced for the cycle after that edge.
REQ-018 In GRANT with req[gnt_idx] = 1, hcnt == MAX_HOLD, and no other req bit set, SHALL keep the grant, reset hcnt to 1, and leave forced low.
REQ-019 SHALL always insert at least one IDLE cycle (gnt == 0) between successive grants, including a re-grant to the same requester; this is the bus turnaround.
REQ-020 Request changes on non-owner bits during GRANT SHALL NOT affect the current grant.
REQ-021 SHALL never assert more than one gnt bit in any cycle.
REQ-022 forced SHALL be low in every cycle except the single cycle defined in REQ-017.
REQ-023 All outputs SHALL be registered, with no combinational path from req to any output.

Reset
REQ-024 While rst_n = 0, SHALL immediately force state = IDLE, gnt = 0, gnt_idx = 0, gnt_valid = 0, forced = 0, ptr = 0, and hcnt = 0, independent of clk.
REQ-025 Reset asserted mid-grant SHALL drop the grant with no turnaround cycle and no forced pulse.
REQ-026 After rst_n deasserts, the first arbitration SHALL start from ptr = 0.

Verification
REQ-027 Scenario: reset, then req = 8'h24 held -> one edge later gnt = 8'h04, gnt_idx = 2; drop req[2] -> next cycle gnt = 0; next edge gnt = 8'h20, gnt_idx = 5.
REQ-028 Scenario: all req = 8'hFF, each owner drops req 3 cycles after its grant -> the grant order is 0,1,2,...,7,0, with exactly one gnt = 0 cycle between each pair of grants.
REQ-029 Scenario: with MAX_HOLD = 4, req = 8'h81, requester 0 never releases -> gnt = 8'h01 for exactly 4 cycles, then forced = 1 with gnt = 0 for one cycle, then gnt = 8'h80.
REQ-030 Scenario: with MAX_HOLD = 4, req = 8'h01 alone held for 20 cycles -> gnt = 8'h01 continuously and forced never asserts.
REQ-031 Scenario: owner 7 releases -> ptr wraps to 0; with req = 8'h81 the next grant goes to 0, not 7.
REQ-032 Scenario: rst_n pulsed low mid-cycle during a grant to requester 3 -> gnt = 0 asynchronously; after release with req = 8'h0C held, the next grant goes to requester 2.
